// File: rtl/controller_pkg.sv
// Shared state definitions for the shift-and-add multiplier controller.
package controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

endpackage

// File: rtl/controller.sv
// Sequencer for a shift-and-add multiplier: one ADD then one SHIFT per operand bit,
// returning to idle when the datapath reports the bit counter has reached zero.
module controller
  import controller_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Q0,
  input  logic Zero,
  output logic Ready,
  output logic Load_Regs,
  output logic Shift_Regs,
  output logic Add_Regs,
  output logic Decr_P
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The unused code 11 falls into the default branch: outputs low, back to idle.
  always_comb begin
    w_next     = S_IDLE;
    Ready      = 1'b0;
    Load_Regs  = 1'b0;
    Shift_Regs = 1'b0;
    Add_Regs   = 1'b0;
    Decr_P     = 1'b0;
    case (r_state)
      S_IDLE: begin
        Ready     = 1'b1;
        Load_Regs = Start & Reset;
        w_next    = Start ? S_ADD : S_IDLE;
      end
      S_ADD: begin
        Decr_P   = 1'b1;
        Add_Regs = Q0;
        w_next   = S_SHIFT;
      end
      S_SHIFT: begin
        Shift_Regs = 1'b1;
        w_next     = Zero ? S_IDLE : S_ADD;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Randomized self-checking bench for controller against a phase-level reference model.
module tb_controller;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic Q0 = 1'b0;
  logic Zero = 1'b0;
  logic Ready, Load_Regs, Shift_Regs, Add_Regs, Decr_P;

  int checkCount = 0;
  int passCount = 0;

  // Model: is an operation in progress, and is the next bit phase the add phase?
  bit mBusy = 1'b0;
  bit mAddPhase = 1'b0;

  controller dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Q0(Q0),
    .Zero(Zero),
    .Ready(Ready),
    .Load_Regs(Load_Regs),
    .Shift_Regs(Shift_Regs),
    .Add_Regs(Add_Regs),
    .Decr_P(Decr_P)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic applyStimulus(input logic st, input logic q0, input logic zr, input logic rs);
    bit busy;
    bit addPh;
    Start = st;
    Q0    = q0;
    Zero  = zr;
    Reset = rs;
    #2;
    busy  = rs ? mBusy : 1'b0;
    addPh = busy && mAddPhase;
    checkOutput("Ready", Ready, !busy);
    checkOutput("Load_Regs", Load_Regs, !busy && st && rs);
    checkOutput("Decr_P", Decr_P, addPh);
    checkOutput("Add_Regs", Add_Regs, addPh && q0);
    checkOutput("Shift_Regs", Shift_Regs, busy && !mAddPhase);
    if (!rs) begin
      mBusy = 1'b0;
      mAddPhase = 1'b0;
    end else if (!mBusy) begin
      if (st) begin
        mBusy = 1'b1;
        mAddPhase = 1'b1;
      end
    end else if (mAddPhase) begin
      mAddPhase = 1'b0;
    end else if (zr) begin
      mBusy = 1'b0;
    end else begin
      mAddPhase = 1'b1;
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int loads;
    @(posedge Clock);
    #1;

    // Held in reset with Start high.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Single start, then a 4-bit operation: Zero only on the fourth shift.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, i[1], (i == 7), 1'b1);
    end
    #2;
    checkOutput("ready_after_8", Ready, 1'b1);
    #1;
    @(posedge Clock);
    #1;

    // Start pulsed mid-operation is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Reset dropped while shifting.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back operations with Start held and Zero high.
    loads = 0;
    for (int i = 0; i < 9; i++) begin
      Start = 1'b1;
      Zero = 1'b1;
      Q0 = 1'b1;
      Reset = 1'b1;
      #2;
      if (Load_Regs === 1'b1) loads++;
      #(-2 + 2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("back_to_back_loads", loads, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) != 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
